// File: rtl/event_counter_pkg.sv
// Shared types and sizing helpers for the event_counter gate/readout controller.
package event_counter_pkg;
    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [3:0] HDR_TAG = 4'hA;
    localparam int         DROP_W  = 16;

    function automatic int words_per_cnt(input int width, input int out_w);
        return width / out_w;
    endfunction

    // Header word plus every counter split into OUT_W slices.
    function automatic int frame_words(input int ncounters, input int width, input int out_w);
        return 1 + ncounters * words_per_cnt(width, out_w);
    endfunction
endpackage

// File: rtl/event_counter_readout_if.sv
// Valid/ready word stream from the readout controller to the backend packetiser.
interface event_counter_readout_if #(
    parameter int OUT_W = 16
);
    logic [OUT_W-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/event_counter_readout_gate_timer.sv
// Gate period timer: clamps the period to >= 2, detects the enable rising edge
// and flags the last cycle of each gate period.
module gate_timer #(
    parameter int PERIOD_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick,
    output logic                start_pulse
);
    logic                en_q;
    logic [PERIOD_W-1:0] timer;
    logic [PERIOD_W-1:0] p_eff;
    logic [PERIOD_W-1:0] p_clamp;

    assign p_clamp     = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;
    assign start_pulse = enable && !en_q;
    assign tick        = enable && !start_pulse && (timer == p_eff - PERIOD_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q  <= 1'b0;
            timer <= '0;
            p_eff <= PERIOD_W'(2);
        end else begin
            en_q <= enable;
            if (!enable || start_pulse || tick)
                timer <= '0;
            else
                timer <= timer + PERIOD_W'(1);
            // The period only takes effect at a gate boundary.
            if (start_pulse || tick)
                p_eff <= p_clamp;
        end
    end
endmodule

// File: rtl/event_counter_readout.sv
// Gate/readout controller: clears the counter bank each gate period, snapshots the
// pre-clear values and streams them as a framed OUT_W-bit valid/ready sequence.
module event_counter_readout
    import event_counter_pkg::*;
#(
    parameter int NCOUNTERS = 3,
    parameter int WIDTH     = 48,
    parameter int PERIOD_W  = 32,
    parameter int OUT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [PERIOD_W-1:0]        period,
    input  logic [NCOUNTERS*WIDTH-1:0] counters,
    output logic [NCOUNTERS-1:0]       load,
    event_counter_readout_if.master    strm,
    output logic                       busy,
    output logic [DROP_W-1:0]          dropped
);
    localparam int WPC   = words_per_cnt(WIDTH, OUT_W);
    localparam int FW    = frame_words(NCOUNTERS, WIDTH, OUT_W);
    localparam int IDX_W = $clog2(FW);

    state_t                     state, state_n;
    logic                       tick, start_pulse;
    logic [11:0]                seq, seq_inc;
    logic [FW-1:0][OUT_W-1:0]   frame_q, frame_d;
    logic [IDX_W-1:0]           idx;
    logic                       beat, last_xfer, accept, drop;

    gate_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .period      (period),
        .tick        (tick),
        .start_pulse (start_pulse)
    );

    assign load      = {NCOUNTERS{tick | start_pulse}};
    assign seq_inc   = seq + 12'd1;
    assign beat      = (state == SEND) && strm.m_ready;
    assign last_xfer = beat && (idx == IDX_W'(FW - 1));
    assign accept    = tick && ((state == IDLE) || last_xfer);
    assign drop      = tick && !accept;

    assign busy         = (state == SEND);
    assign strm.m_valid = (state == SEND);
    assign strm.m_data  = (state == SEND) ? frame_q[0] : '0;
    assign strm.m_last  = (state == SEND) && (idx == IDX_W'(FW - 1));

    // Frame slot 0 goes out first: header, then each counter MSB slice first.
    always_comb begin
        frame_d    = '0;
        frame_d[0] = {HDR_TAG, seq_inc};
        for (int c = 0; c < NCOUNTERS; c++)
            for (int j = 0; j < WPC; j++)
                frame_d[1 + c*WPC + j] = counters[c*WIDTH + (WPC-1-j)*OUT_W +: OUT_W];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = SEND;
            SEND:    if (last_xfer) state_n = accept ? SEND : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq     <= '0;
            frame_q <= '0;
            idx     <= '0;
            dropped <= '0;
        end else begin
            if (tick)
                seq <= seq_inc;
            if (accept) begin
                frame_q <= frame_d;
                idx     <= '0;
            end else if (beat) begin
                frame_q <= {OUT_W'(0), frame_q[FW-1:1]};
                idx     <= idx + IDX_W'(1);
            end
            if (drop && dropped != '1)
                dropped <= dropped + DROP_W'(1);
        end
    end
endmodule

// File: tb/tb_event_counter_readout.sv
// Directed bench for event_counter_readout: gate timing, frame format, backpressure,
// back-to-back frames, period clamp, mid-frame reset/disable and seq wrap.
module tb_event_counter_readout;
    logic         clk = 1'b0;
    logic         rst, enable, use_bank, sig0;
    logic [31:0]  period;
    logic [143:0] counters, direct;
    logic [2:0]   load;
    logic         busy;
    logic [15:0]  dropped;
    logic [47:0]  bc0;
    int           cyc = 0, checks = 0, fails = 0, s, stall_bad;
    logic [15:0]  bd[$];
    bit           bl[$];
    int           bcyc[$], ldq[$];
    logic [2:0]   ldv[$];

    localparam logic [143:0] D2 = {48'hFFFF_FFFF_FFFF, 48'hABCD_0000_1234, 48'h0000_0000_0001};
    localparam logic [143:0] D1 = {48'h0000_0000_0003, 48'h0002_0000_0000, 48'h1234_5678_9ABC};
    localparam logic [143:0] DX = {48'h1111_2222_3333, 48'h4444_5555_6666, 48'h7777_8888_9999};

    event_counter_readout_if #(.OUT_W(16)) strm ();

    event_counter_readout #(.NCOUNTERS(3), .WIDTH(48), .PERIOD_W(32), .OUT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period), .counters(counters),
        .load(load), .strm(strm), .busy(busy), .dropped(dropped)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Minimal stand-in for counter 0 of the bank.
    always @(posedge clk) begin
        if (rst || load[0]) bc0 <= '0;
        else if (sig0)      bc0 <= bc0 + 48'd1;
    end
    assign counters = use_bank ? {96'd0, bc0} : direct;

    always @(negedge clk) begin
        if (!rst) begin
            if (strm.m_valid && strm.m_ready) begin
                bd.push_back(strm.m_data); bl.push_back(strm.m_last); bcyc.push_back(cyc);
            end
            if (load != 3'b000) begin
                ldq.push_back(cyc); ldv.push_back(load);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bd.delete(); bl.delete(); bcyc.delete(); ldq.delete(); ldv.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; strm.m_ready = 1'b1;
        go(2);
        rst = 1'b0;
        go(1);
        clr();
    endtask

    task automatic chk_frame(input string tag, input int base, input logic [15:0] w [10]);
        chk({tag, "_size"}, 64'(bd.size() >= base + 10), 64'd1);
        if (bd.size() >= base + 10)
            for (int k = 0; k < 10; k++) begin
                chk($sformatf("%s_w%0d", tag, k), 64'(bd[base+k]), 64'(w[k]));
                chk($sformatf("%s_last%0d", tag, k), 64'(bl[base+k]), 64'(k == 9));
            end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; period = 32'd10; strm.m_ready = 1'b1;
        use_bank = 1'b1; sig0 = 1'b0; direct = '0;
        go(3);
        @(negedge clk);
        chk("rst_valid", 64'(strm.m_valid), 64'd0);
        chk("rst_last", 64'(strm.m_last), 64'd0);
        chk("rst_data", 64'(strm.m_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_dropped", 64'(dropped), 64'd0);
        chk("rst_load", 64'(load), 64'd0);
        rst = 1'b0;
        go(1);
        clr();

        // Bank counting: 3 pulses, back-to-back second frame, disable at word 5 of frame 2.
        enable = 1'b1; s = cyc;
        go(2); sig0 = 1'b1; go(1); sig0 = 1'b0; go(1); sig0 = 1'b1; go(1);
        sig0 = 1'b0; go(1); sig0 = 1'b1; go(1); sig0 = 1'b0;
        go(19);
        enable = 1'b0;
        go(15);
        chk_frame("bank_f1", 0, '{16'hA001, 0, 0, 16'h0003, 0, 0, 0, 0, 0, 0});
        chk_frame("b2b_f2", 10, '{16'hA002, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        chk("bank_nbeats", 64'(bd.size()), 64'd20);
        if (bcyc.size() >= 11) begin
            chk("lat_word0", 64'(bcyc[0] - s), 64'd11);
            chk("b2b_hdr_cyc", 64'(bcyc[10] - s), 64'd21);
        end
        chk("nloads", 64'(ldq.size()), 64'd3);
        if (ldq.size() >= 3) begin
            chk("load_edge", 64'(ldq[0] - s), 64'd0);
            chk("load_p1", 64'(ldq[1] - s), 64'd10);
            chk("load_p2", 64'(ldq[2] - s), 64'd20);
            chk("load_val", 64'(ldv[0]), 64'h7);
        end
        chk("b2b_dropped", 64'(dropped), 64'd0);

        // Frame format with directly driven counter values.
        do_reset();
        use_bank = 1'b0; direct = D2; period = 32'd10;
        enable = 1'b1; s = cyc;
        go(12); enable = 1'b0; go(12);
        chk_frame("fmt", 0, '{16'hA001, 16'h0000, 16'h0000, 16'h0001, 16'hABCD, 16'h0000,
                              16'h1234, 16'hFFFF, 16'hFFFF, 16'hFFFF});
        chk("fmt_nbeats", 64'(bd.size()), 64'd10);

        // Backpressure: word0 held, later ticks dropped, original snapshot kept.
        do_reset();
        direct = D1; period = 32'd4; strm.m_ready = 1'b0; stall_bad = 0;
        enable = 1'b1; s = cyc;
        go(5);
        direct = DX;
        for (int k = 5; k < 25; k++) begin
            @(negedge clk);
            if (!(strm.m_valid && strm.m_data == 16'hA001 && !strm.m_last)) stall_bad++;
            if (k == 9)  chk("bp_drop1", 64'(dropped), 64'd1);
            if (k == 13) chk("bp_drop2", 64'(dropped), 64'd2);
            go(1);
        end
        chk("bp_hold", 64'(stall_bad), 64'd0);
        enable = 1'b0; strm.m_ready = 1'b1;
        @(negedge clk);
        chk("bp_drop5", 64'(dropped), 64'd5);
        go(15);
        chk_frame("bp", 0, '{16'hA001, 16'h1234, 16'h5678, 16'h9ABC, 16'h0002, 16'h0000,
                             16'h0000, 16'h0000, 16'h0000, 16'h0003});
        chk("bp_drop_end", 64'(dropped), 64'd5);

        // period=1 clamps to 2.
        do_reset();
        period = 32'd1; enable = 1'b1; s = cyc;
        go(7); enable = 1'b0; go(14);
        chk("p1_nloads", 64'(ldq.size()), 64'd4);
        if (ldq.size() >= 4)
            for (int k = 1; k < 4; k++) chk($sformatf("p1_load%0d", k), 64'(ldq[k] - s), 64'(2 * k));

        // period=0 clamps to 2; ticks during a frame are dropped except the last-beat one.
        do_reset();
        period = 32'd0; enable = 1'b1; s = cyc;
        go(14);
        chk("p0_dropped", 64'(dropped), 64'd4);
        enable = 1'b0;
        go(12);
        chk("p0_nloads", 64'(ldq.size()), 64'd7);
        if (ldq.size() >= 2) chk("p0_load1", 64'(ldq[1] - s), 64'd2);
        chk("p0_nbeats", 64'(bd.size()), 64'd20);

        // Reset mid-frame (dropped still 4 from above).
        clr();
        direct = D2; period = 32'd10; enable = 1'b1; s = cyc;
        go(15);
        @(negedge clk);
        chk("mrst_pre_data", 64'(strm.m_data), 64'hABCD);
        chk("mrst_pre_busy", 64'(busy), 64'd1);
        chk("mrst_pre_drop", 64'(dropped), 64'd4);
        rst = 1'b1; enable = 1'b0;
        go(1);
        @(negedge clk);
        chk("mrst_valid", 64'(strm.m_valid), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_dropped", 64'(dropped), 64'd0);
        rst = 1'b0;
        go(2);

        // Sequence number wraps 0xFFF -> 0x000.
        do_reset();
        period = 32'd10; enable = 1'b1; s = cyc;
        go(40975);
        enable = 1'b0;
        go(15);
        chk("wrap_nbeats", 64'(bd.size()), 64'd40970);
        if (bd.size() >= 40970) begin
            chk("wrap_fff", 64'(bd[40940]), 64'hAFFF);
            chk("wrap_000", 64'(bd[40950]), 64'hA000);
            chk("wrap_001", 64'(bd[40960]), 64'hA001);
        end
        chk("wrap_dropped", 64'(dropped), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
